// File: rtl/msu_pkg.sv
// Shared state encoding, frame geometry helpers and default squarer widths
// for the MSU checkpointing wrapper.
package msu_pkg;

  // Default squarer widths, kept in step with the redundant Montgomery squarer build.
  localparam int DAT_BITS = 1024;
  localparam int TOT_BITS = 1056;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RECV,
    ST_LOAD,
    ST_START,
    ST_COMPUTE,
    ST_DRAIN,
    ST_IDLE
  } msu_state_e;

  // Field offsets inside the input and output frames, LSW first.
  localparam int T_START_OFS = 0;
  localparam int T_DONE_OFS  = 0;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int in_cnt(input int axi_len, input int t_len, input int sq_in_bits);
    return ceil_div(3 * t_len + sq_in_bits, axi_len);
  endfunction

  function automatic int out_cnt(input int axi_len, input int t_len, input int sq_out_bits);
    return ceil_div(t_len + sq_out_bits, axi_len);
  endfunction

  function automatic int t_final_ofs(input int t_len);
    return t_len;
  endfunction

  function automatic int interval_ofs(input int t_len);
    return 2 * t_len;
  endfunction

  function automatic int sq_in_ofs(input int t_len);
    return 3 * t_len;
  endfunction

  function automatic int sq_hold_ofs(input int t_len);
    return t_len;
  endfunction

endpackage

// File: rtl/msu_frame_tx.sv
// Output frame serializer with one pending slot: checkpoints are dropped when
// busy, the final frame waits in the slot and is sent next.
module msu_frame_tx
  import msu_pkg::*;
#(
  parameter int AXI_LEN     = 32,
  parameter int T_LEN       = 64,
  parameter int SQ_OUT_BITS = TOT_BITS
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fr_vld,
  input  logic                   fr_final,
  input  logic [T_LEN-1:0]       fr_tdone,
  input  logic [SQ_OUT_BITS-1:0] fr_sq,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tvalid,
  output logic [AXI_LEN-1:0]     m_axis_tdata,
  output logic [AXI_LEN/8-1:0]   m_axis_tkeep,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic [7:0]             ckpt_overrun
);

  localparam int OUT_CNT     = out_cnt(AXI_LEN, T_LEN, SQ_OUT_BITS);
  localparam int OUT_W       = OUT_CNT * AXI_LEN;
  localparam int BEAT_W      = (OUT_CNT > 1) ? $clog2(OUT_CNT) : 1;
  localparam int SQ_HOLD_OFS = sq_hold_ofs(T_LEN);

  function automatic logic [7:0] sat_inc8(input logic [7:0] val);
    return (val == 8'hFF) ? val : val + 8'd1;
  endfunction

  logic [OUT_W-1:0]  fr_word_p0;
  logic [OUT_W-1:0]  sr_p1;
  logic [OUT_W-1:0]  pend_p1;
  logic              vld_p1;
  logic              user_p1;
  logic              pend_vld;
  logic [BEAT_W-1:0] beat;
  logic [7:0]        ovr;
  logic              hs;
  logic              last_hs;
  logic              free;
  logic              take_new;

  always_comb begin
    fr_word_p0 = '0;
    fr_word_p0[T_DONE_OFS +: T_LEN]        = fr_tdone;
    fr_word_p0[SQ_HOLD_OFS +: SQ_OUT_BITS] = fr_sq;
  end

  assign hs       = vld_p1 && m_axis_tready && !rst;
  assign last_hs  = hs && (beat == BEAT_W'(OUT_CNT - 1));
  assign free     = !vld_p1 || last_hs;
  // A new frame goes straight to the serializer only if nothing is queued ahead of it.
  assign take_new = free && !pend_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      pend_vld <= 1'b0;
      beat     <= '0;
      ovr      <= 8'd0;
    end else begin
      if (hs) beat <= last_hs ? '0 : beat + BEAT_W'(1);
      if (free) begin
        if (pend_vld) begin
          vld_p1   <= 1'b1;
          pend_vld <= 1'b0;
        end else begin
          vld_p1 <= fr_vld;
        end
      end
      if (fr_vld && !take_new) begin
        if (fr_final) pend_vld <= 1'b1;
        else          ovr      <= sat_inc8(ovr);
      end
    end
  end

  // Serializer stage: load a whole frame, then shift one beat out per handshake.
  always_ff @(posedge clk) begin
    if (free && pend_vld) begin
      sr_p1   <= pend_p1;
      user_p1 <= 1'b1;
    end else if (take_new && fr_vld) begin
      sr_p1   <= fr_word_p0;
      user_p1 <= fr_final;
    end else if (hs) begin
      sr_p1 <= sr_p1 >> AXI_LEN;
    end
    if (fr_vld && fr_final && !take_new) pend_p1 <= fr_word_p0;
  end

  assign m_axis_tvalid = vld_p1 && !rst;
  assign m_axis_tdata  = m_axis_tvalid ? sr_p1[AXI_LEN-1:0] : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? '1 : '0;
  assign m_axis_tlast  = m_axis_tvalid && (beat == BEAT_W'(OUT_CNT - 1));
  assign m_axis_tuser  = m_axis_tvalid && user_p1;
  assign ckpt_overrun  = rst ? 8'd0 : ovr;

endmodule

// File: rtl/msu_ckpt.sv
// Job controller around an external squarer: receives a job frame, runs the
// iterations and streams out checkpoint and final result frames.
module msu_ckpt
  import msu_pkg::*;
#(
  parameter int AXI_LEN           = 32,
  parameter int T_LEN             = 64,
  parameter int SQ_IN_BITS        = DAT_BITS,
  parameter int SQ_OUT_BITS       = TOT_BITS,
  parameter int C_XFER_SIZE_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ap_start,
  input  logic                         ap_abort,
  output logic                         ap_done,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [AXI_LEN-1:0]           s_axis_tdata,
  input  logic                         s_axis_tlast,
  output logic [C_XFER_SIZE_WIDTH-1:0] s_axis_xfer_size_in_bytes,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [AXI_LEN-1:0]           m_axis_tdata,
  output logic [AXI_LEN/8-1:0]         m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic                         m_axis_tuser,
  output logic [C_XFER_SIZE_WIDTH-1:0] m_axis_xfer_size_in_bytes,
  output logic                         sq_reset,
  output logic                         sq_start,
  output logic [SQ_IN_BITS-1:0]        sq_in,
  input  logic [SQ_OUT_BITS-1:0]       sq_out,
  input  logic                         sq_valid,
  input  logic                         sq_locked,
  output logic [7:0]                   ckpt_overrun
);

  localparam int IN_CNT       = in_cnt(AXI_LEN, T_LEN, SQ_IN_BITS);
  localparam int OUT_CNT      = out_cnt(AXI_LEN, T_LEN, SQ_OUT_BITS);
  localparam int IN_W         = IN_CNT * AXI_LEN;
  localparam int T_FINAL_OFS  = t_final_ofs(T_LEN);
  localparam int INTERVAL_OFS = interval_ofs(T_LEN);
  localparam int SQ_IN_OFS    = sq_in_ofs(T_LEN);

  logic                   reset_q;
  logic                   rst_any;
  msu_state_e             state;
  logic                   sq_start_r;
  logic                   ap_done_r;
  logic [IN_W-1:0]        in_sr;
  logic [T_LEN-1:0]       t_current;
  logic [T_LEN-1:0]       t_final_r;
  logic [T_LEN-1:0]       interval_r;
  logic [T_LEN-1:0]       ckpt_cnt;
  logic [SQ_IN_BITS-1:0]  sq_in_r;
  logic [SQ_OUT_BITS-1:0] sq_hold;

  logic                   s_hs;
  logic                   early_exit;
  logic                   iter;
  logic                   last_iter;
  logic                   abort_req;
  logic                   fin;
  logic                   ckpt;
  logic                   final_hs;
  logic                   fr_vld_p0;
  logic                   fr_final_p0;
  logic [T_LEN-1:0]       fr_tdone_p0;
  logic [SQ_OUT_BITS-1:0] fr_sq_p0;

  assign rst_any = reset || reset_q;

  assign s_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(IN_CNT * AXI_LEN / 8);
  assign m_axis_xfer_size_in_bytes = C_XFER_SIZE_WIDTH'(OUT_CNT * AXI_LEN / 8);

  always_comb begin
    s_hs       = s_axis_tvalid && s_axis_tready;
    // An empty iteration range ends COMPUTE at once, before any squarer result.
    early_exit = (state == ST_COMPUTE) && (t_final_r <= t_current);
    iter       = (state == ST_COMPUTE) && !early_exit && sq_valid;
    last_iter  = iter && (t_current == t_final_r - T_LEN'(1));
    abort_req  = (state == ST_COMPUTE) && !early_exit && ap_abort;
    fin        = early_exit || last_iter || abort_req;
    ckpt       = iter && (interval_r != '0) && (ckpt_cnt == T_LEN'(1)) && !fin;
    final_hs   = m_axis_tvalid && m_axis_tready && m_axis_tlast && m_axis_tuser;
  end

  // Frame request stage: post-update values whenever a result lands this cycle.
  always_comb begin
    fr_vld_p0   = fin || ckpt;
    fr_final_p0 = fin;
    fr_tdone_p0 = iter ? t_current + T_LEN'(1) : t_current;
    fr_sq_p0    = iter ? sq_out : sq_hold;
  end

  always_ff @(posedge clk) begin
    reset_q <= reset;
    if (rst_any) begin
      state      <= ST_INIT;
      sq_start_r <= 1'b0;
      ap_done_r  <= 1'b0;
    end else begin
      sq_start_r <= 1'b0;
      ap_done_r  <= 1'b0;
      case (state)
        ST_INIT:    if (ap_start) state <= ST_RECV;
        ST_RECV:    if (s_hs && s_axis_tlast) state <= ST_LOAD;
        ST_LOAD: begin
          state      <= ST_START;
          sq_start_r <= 1'b1;
        end
        ST_START:   state <= ST_COMPUTE;
        ST_COMPUTE: if (fin) state <= ST_DRAIN;
        ST_DRAIN: begin
          if (final_hs) begin
            state     <= ST_IDLE;
            ap_done_r <= 1'b1;
          end
        end
        ST_IDLE:    state <= ST_INIT;
        default:    state <= ST_INIT;
      endcase
    end
  end

  // Job datapath: input shift register, iteration counters and result hold.
  always_ff @(posedge clk) begin
    if (s_hs) in_sr <= (in_sr >> AXI_LEN) | (IN_W'(s_axis_tdata) << (IN_W - AXI_LEN));
    if (state == ST_LOAD) begin
      t_current  <= in_sr[T_START_OFS +: T_LEN];
      t_final_r  <= in_sr[T_FINAL_OFS +: T_LEN];
      interval_r <= in_sr[INTERVAL_OFS +: T_LEN];
      ckpt_cnt   <= in_sr[INTERVAL_OFS +: T_LEN];
      sq_in_r    <= in_sr[SQ_IN_OFS +: SQ_IN_BITS];
      sq_hold    <= SQ_OUT_BITS'(in_sr[SQ_IN_OFS +: SQ_IN_BITS]);
    end else if (iter) begin
      sq_hold   <= sq_out;
      t_current <= t_current + T_LEN'(1);
      ckpt_cnt  <= (ckpt_cnt <= T_LEN'(1)) ? interval_r : ckpt_cnt - T_LEN'(1);
    end
  end

  assign s_axis_tready = (state == ST_RECV) && sq_locked && !rst_any;
  assign sq_reset      = rst_any || (state == ST_INIT) || (state == ST_DRAIN);
  assign sq_start      = sq_start_r && !rst_any;
  assign ap_done       = ap_done_r && !rst_any;
  assign sq_in         = rst_any ? '0 : sq_in_r;

  msu_frame_tx #(
    .AXI_LEN     (AXI_LEN),
    .T_LEN       (T_LEN),
    .SQ_OUT_BITS (SQ_OUT_BITS)
  ) u_frame_tx (
    .clk           (clk),
    .rst           (rst_any),
    .fr_vld        (fr_vld_p0),
    .fr_final      (fr_final_p0),
    .fr_tdone      (fr_tdone_p0),
    .fr_sq         (fr_sq_p0),
    .m_axis_tready (m_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .ckpt_overrun  (ckpt_overrun)
  );

endmodule

// File: tb/tb_msu_ckpt.sv
// Directed bench for msu_ckpt: a table of jobs with hand-computed frames plus
// abort and mid-frame reset sequences against an x+1 squarer model.
module tb_msu_ckpt;
  import msu_pkg::*;

  localparam int AXI_LEN = 32;
  localparam int T_LEN   = 64;
  localparam int SQI     = 128;
  localparam int SQO     = 136;
  localparam int XW      = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset = 1'b1;
  logic           ap_start = 1'b0, ap_abort = 1'b0, ap_done;
  logic           s_axis_tvalid = 1'b0, s_axis_tready, s_axis_tlast = 1'b0;
  logic [31:0]    s_axis_tdata = '0;
  logic [XW-1:0]  s_xfer, m_xfer;
  logic           m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tlast, m_axis_tuser;
  logic [31:0]    m_axis_tdata;
  logic [3:0]     m_axis_tkeep;
  logic           sq_reset, sq_start, sq_valid = 1'b0, sq_locked = 1'b1;
  logic [SQI-1:0] sq_in;
  logic [SQO-1:0] sq_out = '0;
  logic [7:0]     ckpt_overrun;

  msu_ckpt #(
    .AXI_LEN(AXI_LEN), .T_LEN(T_LEN), .SQ_IN_BITS(SQI), .SQ_OUT_BITS(SQO), .C_XFER_SIZE_WIDTH(XW)
  ) dut (
    .clk(clk), .reset(reset), .ap_start(ap_start), .ap_abort(ap_abort), .ap_done(ap_done),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_axis_tlast(s_axis_tlast), .s_axis_xfer_size_in_bytes(s_xfer),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .m_axis_xfer_size_in_bytes(m_xfer),
    .sq_reset(sq_reset), .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out),
    .sq_valid(sq_valid), .sq_locked(sq_locked), .ckpt_overrun(ckpt_overrun)
  );

  // Squarer model: returns x+1 every 4 cycles, starting from sq_in.
  logic [SQO-1:0] sq_cur = '0;
  int             sq_div = 0;
  logic           sq_run = 1'b0;
  always @(posedge clk) begin
    if (sq_reset) begin
      sq_run <= 1'b0; sq_div <= 0; sq_valid <= 1'b0;
    end else begin
      sq_valid <= 1'b0;
      if (sq_start) begin
        sq_run <= 1'b1; sq_div <= 0; sq_cur <= SQO'(sq_in);
      end else if (sq_run) begin
        if (sq_div == 3) begin
          sq_div <= 0; sq_cur <= sq_cur + 1; sq_out <= sq_cur + 1; sq_valid <= 1'b1;
        end else begin
          sq_div <= sq_div + 1;
        end
      end
    end
  end

  // Output monitor, sampled on the falling edge.
  logic [223:0] mon_buf = '0;
  int           mon_beat = 0;
  bit           mon_user, mon_bad;
  int           sqv_cnt = 0;
  logic [223:0] q_frame[$];
  bit           q_user[$];
  int           q_beats[$];
  bit           q_bad[$];

  always @(negedge clk) begin
    if (sq_valid) sqv_cnt++;
    if (reset) begin
      mon_beat = 0;
    end else if (m_axis_tvalid && m_axis_tready) begin
      if (mon_beat == 0) begin mon_buf = '0; mon_user = m_axis_tuser; mon_bad = 1'b0; end
      if (mon_beat < 7) mon_buf[mon_beat*32 +: 32] = m_axis_tdata;
      if (m_axis_tuser !== mon_user || m_axis_tkeep !== 4'hF) mon_bad = 1'b1;
      mon_beat++;
      if (m_axis_tlast) begin
        q_frame.push_back(mon_buf); q_user.push_back(mon_user);
        q_beats.push_back(mon_beat); q_bad.push_back(mon_bad);
        mon_beat = 0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [63:0]          t_start, t_final, interval;
    logic [127:0]         sq_in;
    int                   hold;
    int                   nfr;
    logic [2:0][63:0]     tdone;
    logic [2:0]           user;
    logic [2:0][135:0]    sq;
    int                   ovr;
    int                   sqv;
  } job_t;

  task automatic do_reset();
    reset = 1'b1; ap_start = 1'b0; ap_abort = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; m_axis_tready = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_sq_reset", sq_reset, 1);
    check("rst_ap_done", ap_done, 0);
    check("rst_ovr", ckpt_overrun, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q_frame.delete(); q_user.delete(); q_beats.delete(); q_bad.delete();
    sqv_cnt = 0;
  endtask

  task automatic send_job(input job_t j, input string tag);
    logic [319:0] w;
    bit ok;
    w  = {j.sq_in, j.interval, j.t_final, j.t_start};
    ok = 1'b1;
    ap_start = 1'b1; @(posedge clk); #1; ap_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit hs;
      int g;
      g = 0;
      s_axis_tvalid = 1'b1; s_axis_tdata = w[i*32 +: 32]; s_axis_tlast = (i == 9);
      do begin
        @(negedge clk); hs = s_axis_tready;
        @(posedge clk); #1; g++;
      end while (!hs && g < 100);
      if (!hs) ok = 1'b0;
    end
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    check({tag, "_in_hs"}, ok, 1);
  endtask

  task automatic wait_done(input int hold, input string tag);
    int cyc;
    bit seen;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 2000) begin
      m_axis_tready = (cyc >= hold);
      @(negedge clk); seen = ap_done;
      @(posedge clk); #1; cyc++;
    end
    check({tag, "_ap_done"}, seen, 1);
    @(negedge clk);
    check({tag, "_ap_done_pulse"}, ap_done, 0);
  endtask

  task automatic check_frames(input job_t j, input string tag);
    check({tag, "_nframes"}, q_frame.size(), j.nfr);
    for (int k = 0; k < j.nfr && k < q_frame.size(); k++) begin
      check($sformatf("%s_f%0d_tdone", tag, k), q_frame[k][63:0], j.tdone[k]);
      check($sformatf("%s_f%0d_sq", tag, k), q_frame[k][199:64], j.sq[k]);
      check($sformatf("%s_f%0d_pad", tag, k), q_frame[k][223:200], 0);
      check($sformatf("%s_f%0d_tuser", tag, k), q_user[k], j.user[k]);
      check($sformatf("%s_f%0d_beats", tag, k), q_beats[k], 7);
      check($sformatf("%s_f%0d_keep_user", tag, k), q_bad[k], 0);
    end
  endtask

  task automatic wait_iters(input int n, input string tag);
    int g;
    g = 0;
    while (sqv_cnt < n && g < 500) begin @(posedge clk); #1; g++; end
    check({tag, "_iters"}, sqv_cnt >= n, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  job_t jobs[4];
  job_t aj;

  initial begin
    jobs[0] = '{t_start:64'd0, t_final:64'd5, interval:64'd0, sq_in:128'd7, hold:0, nfr:1,
                tdone:{64'd0, 64'd0, 64'd5}, user:3'b001, sq:{136'd0, 136'd0, 136'd12},
                ovr:0, sqv:5};
    jobs[1] = '{t_start:64'd0, t_final:64'd6, interval:64'd2, sq_in:128'd20, hold:0, nfr:3,
                tdone:{64'd6, 64'd4, 64'd2}, user:3'b100, sq:{136'd26, 136'd24, 136'd22},
                ovr:0, sqv:6};
    jobs[2] = '{t_start:64'd0, t_final:64'd6, interval:64'd2, sq_in:128'd20, hold:40, nfr:2,
                tdone:{64'd0, 64'd6, 64'd2}, user:3'b010, sq:{136'd0, 136'd26, 136'd22},
                ovr:1, sqv:6};
    jobs[3] = '{t_start:64'd10, t_final:64'd10, interval:64'd0, sq_in:128'd3, hold:0, nfr:1,
                tdone:{64'd0, 64'd0, 64'd10}, user:3'b001, sq:{136'd0, 136'd0, 136'd3},
                ovr:0, sqv:0};

    check("s_xfer_size", s_xfer, 40);
    check("m_xfer_size", m_xfer, 28);

    for (int n = 0; n < 4; n++) begin
      string tag;
      tag = $sformatf("job%0d", n);
      do_reset();
      send_job(jobs[n], tag);
      wait_done(jobs[n].hold, tag);
      check_frames(jobs[n], tag);
      check({tag, "_overrun"}, ckpt_overrun, jobs[n].ovr);
      check({tag, "_sq_valids"}, sqv_cnt, jobs[n].sqv);
    end

    // Abort after three iterations of a long job.
    aj = '{t_start:64'd0, t_final:64'd100, interval:64'd0, sq_in:128'd50, hold:0, nfr:1,
           tdone:{64'd0, 64'd0, 64'd3}, user:3'b001, sq:{136'd0, 136'd0, 136'd53},
           ovr:0, sqv:3};
    do_reset();
    send_job(aj, "abort");
    wait_iters(3, "abort");
    ap_abort = 1'b1; @(posedge clk); #1; ap_abort = 1'b0;
    wait_done(0, "abort");
    check_frames(aj, "abort");
    check("abort_sq_valids", sqv_cnt, 3);

    // Same abort, then reset in the middle of sending the final frame.
    do_reset();
    send_job(aj, "rstmid");
    wait_iters(3, "rstmid");
    ap_abort = 1'b1; @(posedge clk); #1; ap_abort = 1'b0;
    m_axis_tready = 1'b1;
    begin
      int g;
      g = 0;
      while (mon_beat < 3 && g < 200) begin @(posedge clk); #1; g++; end
      check("rstmid_beats_started", mon_beat >= 3, 1);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rstmid_tvalid", m_axis_tvalid, 0);
    check("rstmid_state", dut.state, ST_INIT);
    check("rstmid_sq_reset", sq_reset, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rstmid_tvalid_after", m_axis_tvalid, 0);
    check("rstmid_state_after", dut.state, ST_INIT);
    check("rstmid_no_frame", q_frame.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
